// File: rtl/fifo8_ctrl_pkg.sv
// Shared types and sizes for the fifo8_ctrl FIFO and its RAM8 storage.
// Word width, RAM depth, pointer and count widths, arbitration op codes.
package fifo8_ctrl_pkg;

    localparam int FIFO8_W  = 16;
    localparam int FIFO8_D  = 8;
    localparam int FIFO8_AW = 3;
    localparam int FIFO8_CW = 4;

    typedef logic [FIFO8_W-1:0]  word_t;
    typedef logic [FIFO8_AW-1:0] ptr_t;
    typedef logic [FIFO8_CW-1:0] cnt_t;

    // One RAM operation (or none) per cycle.
    typedef enum logic [1:0] {
        OP_IDLE   = 2'd0,
        OP_BYPASS = 2'd1,
        OP_REFILL = 2'd2,
        OP_WRITE  = 2'd3
    } op_t;

    localparam cnt_t RAM_FULL = cnt_t'(FIFO8_D);

    // Saturating-free count of stored words: RAM words plus the OR word.
    function automatic cnt_t total_count(input cnt_t ram_cnt, input logic held);
        return ram_cnt + {{(FIFO8_CW-1){1'b0}}, held};
    endfunction

endpackage

// File: rtl/fifo8_ctrl_ram8.sv
// RAM8 storage: 8 x 16 words, combinational read, write on clk.
// Single port; the controller chooses read or write address each cycle.
module fifo8_ctrl_ram8
    import fifo8_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic [2:0]  addr,
    input  logic        write,
    input  logic [15:0] in,
    output logic [15:0] out
);

    word_t mem [FIFO8_D];

    // Store the input word at addr when write is high.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[addr] <= in;
        end
    end

    // Asynchronous read of the addressed word.
    always_comb begin
        out = mem[addr];
    end

endmodule

// File: rtl/fifo8_ctrl.sv
// fifo8_ctrl: 9-word valid/ready FIFO, 8 words in RAM8 plus an output register.
// Define FIFO8_PUSH_PRIO_EN to let a push win the RAM port over a refill.
module fifo8_ctrl
    import fifo8_ctrl_pkg::*;
#(
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  count,
    output logic        almost_full,
    output logic        almost_empty
);

    localparam cnt_t AF_CNT = cnt_t'(AF_LVL);
    localparam cnt_t AE_CNT = cnt_t'(AE_LVL);

    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    cnt_t  ram_cnt;
    op_t   op;

    logic  ram_empty;
    logic  ram_full;
    logic  or_free;
    logic  push;

    ptr_t  ram_addr;
    logic  ram_write;
    word_t ram_out;

    // Occupancy flags and the handshake toward the producer.
    always_comb begin
        ram_empty = (ram_cnt == '0);
        ram_full  = (ram_cnt == RAM_FULL);
        or_free   = !out_valid || out_ready;
`ifdef FIFO8_PUSH_PRIO_EN
        in_ready  = !ram_full || (ram_empty && or_free);
`else
        in_ready  = !ram_full && !(!ram_empty && or_free);
`endif
        push      = in_valid && in_ready;
    end

    // Pick the single RAM operation for this cycle.
    always_comb begin
        op = OP_IDLE;
`ifdef FIFO8_PUSH_PRIO_EN
        if (ram_empty && or_free && push) begin
            op = OP_BYPASS;
        end else if (push) begin
            op = OP_WRITE;
        end else if (!ram_empty && or_free) begin
            op = OP_REFILL;
        end
`else
        if (ram_empty && or_free && push) begin
            op = OP_BYPASS;
        end else if (!ram_empty && or_free) begin
            op = OP_REFILL;
        end else if (push) begin
            op = OP_WRITE;
        end
`endif
    end

    // Drive the RAM port: write address on WRITE, read address otherwise.
    always_comb begin
        ram_write = (op == OP_WRITE);
        ram_addr  = ram_write ? wr_ptr : rd_ptr;
    end

    fifo8_ctrl_ram8 u_ram8 (
        .clk   (clk),
        .addr  (ram_addr),
        .write (ram_write),
        .in    (in_data),
        .out   (ram_out)
    );

    // Advance pointers and the RAM word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
        end else begin
            unique case (op)
                OP_WRITE: begin
                    wr_ptr  <= wr_ptr + 3'd1;
                    ram_cnt <= ram_cnt + 4'd1;
                end
                OP_REFILL: begin
                    rd_ptr  <= rd_ptr + 3'd1;
                    ram_cnt <= ram_cnt - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output register: load on BYPASS or REFILL, hold while not taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= (op == OP_BYPASS) || (op == OP_REFILL) ||
                         (out_valid && !out_ready);
            if (op == OP_BYPASS) begin
                out_data <= in_data;
            end else if (op == OP_REFILL) begin
                out_data <= ram_out;
            end
        end
    end

    // Total occupancy and threshold flags.
    always_comb begin
        count        = total_count(ram_cnt, out_valid);
        almost_full  = (count >= AF_CNT);
        almost_empty = (count <= AE_CNT);
    end

endmodule
